ibuf_rx_capture: RTL and testbench
==================================

IBUF_RX_CAPTURE -- requirements
Module: ibuf_rx_capture

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of pad synchronizer flops; legal range 2..4.
REQ-002 SHALL have parameter FILTER_LEN, default 4, consecutive differing samples needed to accept a new level; legal range 1..16.
REQ-003 SHALL have parameter TURN_CYCLES, default 2, bus-turnaround wait after pad release; legal range 0..15.
REQ-004 SHALL have port C  input  1  clock; one clock, all state on its rising edge.
REQ-005 SHALL have port CLR_N  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port PAD_I  input  1  raw pad level; asynchronous to C.
REQ-007 SHALL have port T  input  1  tristate control of the companion output buffer; 1 = output released; synchronous to C.
REQ-008 SHALL have port GTS  input  1  global tristate; 1 forces release; synchronous to C.
REQ-009 SHALL have port O  output  1  filtered, synchronized pad level.
REQ-010 SHALL have port O_VALID  output  1  high while O reflects a received pad level.
REQ-011 SHALL have port RISE  output  1  one-cycle pulse when O goes 0->1 while receiving.
REQ-012 SHALL have port FALL  output  1  one-cycle pulse when O goes 1->0 while receiving.

Function
REQ-013 SHALL define rel = T | GTS, sampled on each rising edge of C.
REQ-014 SHALL sample PAD_I through a SYNC_STAGES-deep flop chain; the last stage output is s.
REQ-015 SHALL implement states DRIVE, TURN and LISTEN.
REQ-016 DRIVE: rel=1 moves to TURN (TURN_CYCLES>0) or to LISTEN (TURN_CYCLES=0) on the next edge; otherwise stays in DRIVE.
REQ-017 TURN: a turnaround counter loaded with 0 on entry increments each cycle; after TURN_CYCLES cycles in TURN, moves to LISTEN.
REQ-018 Any state with rel=0 SHALL move to DRIVE on the next edge; this takes priority over all other transitions.
REQ-019 DRIVE and TURN: O holds its last value, O_VALID=0, RISE=FALL=0, filter counter held at 0.
REQ-020 On the edge entering LISTEN, O SHALL load s directly, with no RISE/FALL pulse; O_VALID becomes 1 on that same edge.
REQ-021 LISTEN: filter counter (5 bits) increments each cycle s != O and clears to 0 on any cycle s == O.
REQ-022 LISTEN: when s != O and counter == FILTER_LEN-1, O SHALL take s on that edge, the counter clears, and RISE or FALL is set for exactly one cycle.
REQ-023 Latency: a PAD_I change held stable SHALL appear on O exactly SYNC_STAGES+FILTER_LEN edges after the first edge that samples it (6 edges at defaults).
REQ-024 A PAD_I pulse shorter than FILTER_LEN cycles after synchronization SHALL NOT change O and SHALL produce no pulse.
REQ-025 Leaving LISTEN mid-filter SHALL discard the partial count; O keeps its last accepted value.
REQ-026 RISE and FALL SHALL never be high in the same cycle and SHALL never be high while O_VALID=0.
REQ-027 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-028 CLR_N=0 SHALL immediately clear all synchronizer flops, O, O_VALID, RISE, FALL, both counters, and force state DRIVE, independent of C.
REQ-029 The first rising edge of C with CLR_N=1 SHALL evaluate transitions from DRIVE normally; deassertion synchronization is the integrator's responsibility.
REQ-030 Reset asserted in any state SHALL abort turnaround and filtering with no RISE/FALL pulse emitted.

Verification
REQ-031 Defaults, T=0 GTS=0, PAD_I toggling -> O=0, O_VALID=0, RISE=FALL=0 throughout.
REQ-032 Defaults, T 0->1 at edge 0, PAD_I=1 stable -> state DRIVE, TURN, TURN, then LISTEN; O=1 and O_VALID=1 after edge 3; no RISE.
REQ-033 In LISTEN with O=0, PAD_I 0->1 held -> O=1 and RISE high exactly one cycle, 6 edges after first sampling.
REQ-034 In LISTEN with O=1, PAD_I low for 3 cycles then high -> O stays 1, FALL never asserts.
REQ-035 In LISTEN mid-filter (counter=2), T->0 -> DRIVE next edge, O_VALID=0, O unchanged; after re-release, O reloads from s without a pulse.
REQ-036 CLR_N pulsed low between clock edges during LISTEN with O=1 -> O, O_VALID, RISE, FALL = 0 immediately; state DRIVE.

Source files
------------

// File: rtl/ibuf_rx_capture.sv
`default_nettype none
// ============================================================================
//  Module      : ibuf_rx_capture
//  Description : Receive-side capture for a bidirectional pad. Synchronizes
//                the raw pad level, waits out a bus turnaround after the
//                companion output buffer releases, then glitch-filters the
//                level and flags accepted rising/falling transitions.
//  Revision    : 1.0  initial release
// ============================================================================
module ibuf_rx_capture #(
  parameter int SYNC_STAGES = 2,  // pad synchronizer depth, 2..4
  parameter int FILTER_LEN  = 4,  // consecutive differing samples to accept, 1..16
  parameter int TURN_CYCLES = 2   // turnaround wait after release, 0..15
) (
  input  logic C,        // clock
  input  logic CLR_N,    // asynchronous active-low reset
  input  logic PAD_I,    // raw pad level, asynchronous to C
  input  logic T,        // output-buffer tristate control, 1 = released
  input  logic GTS,      // global tristate, 1 forces release
  output logic O,        // filtered, synchronized pad level
  output logic O_VALID,  // O reflects a received pad level
  output logic RISE,     // one-cycle pulse on accepted 0->1
  output logic FALL      // one-cycle pulse on accepted 1->0
);

  // Last filter count value before a new level is accepted.
  localparam logic [4:0] FILT_LAST = 5'(FILTER_LEN - 1);
  // Last turnaround count value before listening begins (unused when
  // TURN_CYCLES is zero since TURN is never entered).
  localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_DRIVE  = 2'd0,
    ST_TURN   = 2'd1,
    ST_LISTEN = 2'd2
  } state_t;

  state_t                 state_q,    state_d;
  logic [SYNC_STAGES-1:0] sync_q,     sync_d;
  logic [3:0]             turn_cnt_q, turn_cnt_d;
  logic [4:0]             filt_cnt_q, filt_cnt_d;
  logic                   o_q,        o_d;
  logic                   valid_q,    valid_d;
  logic                   rise_q,     rise_d;
  logic                   fall_q,     fall_d;

  logic                   rel;  // pad released by the output side
  logic                   s;    // synchronized pad level

  assign rel = T | GTS;
  assign s   = sync_q[SYNC_STAGES-1];

  // Synchronizer chain: PAD_I enters at bit 0 and shifts toward the MSB.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], PAD_I};
  end

  // Turnaround sequencing, level filtering and edge-pulse generation.
  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    filt_cnt_d = 5'd0;
    o_d        = o_q;
    valid_d    = 1'b0;
    rise_d     = 1'b0;
    fall_d     = 1'b0;

    if (!rel) begin
      // Output side is driving the pad: anything sampled now is our own
      // drive, so drop the partial filter count and hold the last level.
      state_d    = ST_DRIVE;
      turn_cnt_d = 4'd0;
    end else begin
      case (state_q)
        ST_DRIVE: begin
          turn_cnt_d = 4'd0;
          if (TURN_CYCLES == 0) begin
            // No turnaround: the level is taken straight from the
            // synchronizer without an edge pulse.
            state_d = ST_LISTEN;
            o_d     = s;
            valid_d = 1'b1;
          end else begin
            state_d = ST_TURN;
          end
        end

        ST_TURN: begin
          if (turn_cnt_q == TURN_LAST) begin
            state_d    = ST_LISTEN;
            turn_cnt_d = 4'd0;
            o_d        = s;
            valid_d    = 1'b1;
          end else begin
            turn_cnt_d = turn_cnt_q + 4'd1;
          end
        end

        ST_LISTEN: begin
          valid_d = 1'b1;
          if (s != o_q) begin
            if (filt_cnt_q == FILT_LAST) begin
              // Level has differed long enough: accept it and flag the edge.
              o_d    = s;
              rise_d = s;
              fall_d = ~s;
            end else begin
              filt_cnt_d = filt_cnt_q + 5'd1;
            end
          end
        end

        default: begin
          state_d    = ST_DRIVE;
          turn_cnt_d = 4'd0;
        end
      endcase
    end
  end

  // State and output registers; reset clears everything regardless of C.
  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q    <= ST_DRIVE;
      sync_q     <= '0;
      turn_cnt_q <= 4'd0;
      filt_cnt_q <= 5'd0;
      o_q        <= 1'b0;
      valid_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      turn_cnt_q <= turn_cnt_d;
      filt_cnt_q <= filt_cnt_d;
      o_q        <= o_d;
      valid_q    <= valid_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  assign O       = o_q;
  assign O_VALID = valid_q;
  assign RISE    = rise_q;
  assign FALL    = fall_q;

endmodule
`default_nettype wire

// File: tb/tb_ibuf_rx_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ibuf_rx_capture
//  Description : Directed, table-driven bench for ibuf_rx_capture at default
//                parameters plus a second instance at the SYNC_STAGES=3,
//                FILTER_LEN=1, TURN_CYCLES=0 corner.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ibuf_rx_capture;

  logic c;
  logic clr_n;
  logic pad, t, gts;
  logic o, o_valid, rise, fall;
  logic pad2, t2, gts2;
  logic o2, o_valid2, rise2, fall2;

  int total;
  int bad;

  typedef struct {
    logic t;
    logic gts;
    logic pad;
    logic o;
    logic v;
    logic r;
    logic f;
  } vec_t;

  vec_t tbl[$];

  ibuf_rx_capture u_dut (
    .C       (c),
    .CLR_N   (clr_n),
    .PAD_I   (pad),
    .T       (t),
    .GTS     (gts),
    .O       (o),
    .O_VALID (o_valid),
    .RISE    (rise),
    .FALL    (fall)
  );

  ibuf_rx_capture #(
    .SYNC_STAGES (3),
    .FILTER_LEN  (1),
    .TURN_CYCLES (0)
  ) u_dut2 (
    .C       (c),
    .CLR_N   (clr_n),
    .PAD_I   (pad2),
    .T       (t2),
    .GTS     (gts2),
    .O       (o2),
    .O_VALID (o_valid2),
    .RISE    (rise2),
    .FALL    (fall2)
  );

  initial begin
    c = 1'b0;
    forever #5 c = ~c;
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk4(input string nm, input logic eo, input logic ev,
                      input logic er, input logic ef);
    chk({nm, "_o"}, o, eo);
    chk({nm, "_valid"}, o_valid, ev);
    chk({nm, "_rise"}, rise, er);
    chk({nm, "_fall"}, fall, ef);
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input string nm, input logic ti, input logic gi, input logic pi,
                      input logic eo, input logic ev, input logic er, input logic ef);
    t   = ti;
    gts = gi;
    pad = pi;
    @(posedge c);
    #1;
    chk4(nm, eo, ev, er, ef);
  endtask

  task automatic step2(input string nm, input logic ti, input logic pi,
                       input logic eo, input logic ev, input logic er, input logic ef);
    t2   = ti;
    pad2 = pi;
    @(posedge c);
    #1;
    chk({nm, "_o"}, o2, eo);
    chk({nm, "_valid"}, o_valid2, ev);
    chk({nm, "_rise"}, rise2, er);
    chk({nm, "_fall"}, fall2, ef);
  endtask

  task automatic add(input logic ti, input logic gi, input logic pi,
                     input logic eo, input logic ev, input logic er, input logic ef);
    tbl.push_back('{ti, gi, pi, eo, ev, er, ef});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clr_n = 1'b0;
    pad = 1'b0; t = 1'b0; gts = 1'b0;
    pad2 = 1'b0; t2 = 1'b0; gts2 = 1'b0;

    //   t  g  pad  o  v  r  f
    // Driving: pad toggles but nothing is received.
    add(0, 0, 1,  0, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0, 0);
    add(0, 0, 1,  0, 0, 0, 0);
    add(0, 0, 0,  0, 0, 0, 0);
    // Release: two TURN cycles, then LISTEN loads s=1 without a pulse.
    add(1, 0, 1,  0, 0, 0, 0);
    add(1, 0, 1,  0, 0, 0, 0);
    add(1, 0, 1,  1, 1, 0, 0);
    add(1, 0, 1,  1, 1, 0, 0);
    // Three-cycle low glitch is rejected.
    for (int i = 0; i < 3; i++) add(1, 0, 0,  1, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 1,  1, 1, 0, 0);
    // Held low: O falls on the 6th edge counting the first sampling edge.
    for (int i = 0; i < 5; i++) add(1, 0, 0,  1, 1, 0, 0);
    add(1, 0, 0,  0, 1, 0, 1);
    add(1, 0, 0,  0, 1, 0, 0);
    // Held high: O rises on the 6th edge with a single RISE pulse.
    for (int i = 0; i < 5; i++) add(1, 0, 1,  0, 1, 0, 0);
    add(1, 0, 1,  1, 1, 1, 0);
    add(1, 0, 1,  1, 1, 0, 0);
    // GTS alone keeps the pad released; dropping both returns to DRIVE.
    add(0, 1, 1,  1, 1, 0, 0);
    add(0, 0, 1,  1, 0, 0, 0);
    add(0, 0, 1,  1, 0, 0, 0);

    // Reset state, checked between clock edges.
    #12;
    chk4("reset", 0, 0, 0, 0);
    chk("reset2_o", o2, 1'b0);
    chk("reset2_valid", o_valid2, 1'b0);
    clr_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i].t, tbl[i].gts, tbl[i].pad,
           tbl[i].o, tbl[i].v, tbl[i].r, tbl[i].f);
    end

    // Mid-filter release drop: partial count discarded, O held, then reload.
    step("mf_turn1",   1, 0, 1,  1, 0, 0, 0);
    step("mf_turn2",   1, 0, 1,  1, 0, 0, 0);
    step("mf_listen",  1, 0, 1,  1, 1, 0, 0);
    step("mf_s1",      1, 0, 0,  1, 1, 0, 0);
    step("mf_c0",      1, 0, 0,  1, 1, 0, 0);
    step("mf_c1",      1, 0, 0,  1, 1, 0, 0);
    step("mf_c2",      1, 0, 0,  1, 1, 0, 0);
    step("mf_drive",   0, 0, 0,  1, 0, 0, 0);
    step("mf_hold",    0, 0, 0,  1, 0, 0, 0);
    step("mf_turn3",   1, 0, 0,  1, 0, 0, 0);
    step("mf_turn4",   1, 0, 0,  1, 0, 0, 0);
    step("mf_reload",  1, 0, 0,  0, 1, 0, 0);
    step("mf_steady",  1, 0, 0,  0, 1, 0, 0);

    // Bring O to 1, then reset asynchronously between edges.
    for (int i = 0; i < 5; i++) step($sformatf("pre_rst%0d", i), 1, 0, 1,  0, 1, 0, 0);
    step("pre_rst_rise", 1, 0, 1,  1, 1, 1, 0);
    step("pre_rst_hold", 1, 0, 1,  1, 1, 0, 0);
    #3;
    clr_n = 1'b0;
    #1;
    chk4("async_rst", 0, 0, 0, 0);
    @(posedge c);
    #1;
    chk4("rst_held", 0, 0, 0, 0);
    #3;
    clr_n = 1'b1;
    // From DRIVE: full two-cycle turnaround, synchronizer refilled from 0.
    step("post_rst_t1", 1, 0, 1,  0, 0, 0, 0);
    step("post_rst_t2", 1, 0, 1,  0, 0, 0, 0);
    step("post_rst_ls", 1, 0, 1,  1, 1, 0, 0);

    // Corner instance: no turnaround, 3-stage sync, single-sample filter.
    step2("c2_listen", 1, 1,  0, 1, 0, 0);
    step2("c2_w1",     1, 1,  0, 1, 0, 0);
    step2("c2_w2",     1, 1,  0, 1, 0, 0);
    step2("c2_rise",   1, 1,  1, 1, 1, 0);
    step2("c2_h1",     1, 0,  1, 1, 0, 0);
    step2("c2_h2",     1, 0,  1, 1, 0, 0);
    step2("c2_h3",     1, 0,  1, 1, 0, 0);
    step2("c2_fall",   1, 0,  0, 1, 0, 1);
    step2("c2_after",  1, 0,  0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
